// File: rtl/digdug_spr_pkg.sv
// Shared constants, bank selects and FSM state type for the sprite-attribute DMA.
package digdug_spr_pkg;

  localparam int unsigned NENT    = 128;
  localparam int unsigned SPAT_AW = 7;
  localparam int unsigned SPAT_W  = 24;
  localparam int unsigned IDX_W   = 8;

  // Bit 17 set marks the sprite as disabled.
  localparam logic [SPAT_W-1:0] CLRWORD = 24'h020000;

  localparam logic [1:0] BANK_LO   = 2'd0;
  localparam logic [1:0] BANK_MID  = 2'd1;
  localparam logic [1:0] BANK_HI   = 2'd2;
  localparam logic [1:0] BANK_NONE = 2'd3;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StCopy,
    StLast
  } spr_state_e;

endpackage

// File: rtl/digdug_spatr_dma_if.sv
// CPU shadow port, renderer attribute port and status lines of the sprite-attribute DMA.
interface digdug_spatr_dma_if;
  import digdug_spr_pkg::*;

  logic                 VBLK;
  logic [SPAT_AW+1:0]   CPUAD;
  logic                 CPUWR;
  logic [7:0]           CPUDI;
  logic [7:0]           CPUDO;
  logic [SPAT_AW-1:0]   SPATAD;
  logic [SPAT_W-1:0]    SPATDT;
  logic                 BUSY;
  logic                 FRAME;

  modport master (
    output VBLK, CPUAD, CPUWR, CPUDI, SPATAD,
    input  CPUDO, SPATDT, BUSY, FRAME
  );

  modport slave (
    input  VBLK, CPUAD, CPUWR, CPUDI, SPATAD,
    output CPUDO, SPATDT, BUSY, FRAME
  );

endinterface

// File: rtl/digdug_spatr_ram.sv
// 128x24 simple dual-port RAM: one write port, one registered write-first read port.
module digdug_spatr_ram
  import digdug_spr_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [SPAT_AW-1:0] i_waddr,
  input  logic [SPAT_W-1:0]  i_wdata,
  input  logic [SPAT_AW-1:0] i_raddr,
  output logic [SPAT_W-1:0]  o_rdata
);

  logic [SPAT_W-1:0] r_mem [NENT];
  logic [SPAT_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Bypass keeps a same-cycle write whole, so a read never mixes old and new bytes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_we && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/digdug_spatr_dma.sv
// Sprite-attribute staging: CPU shadow banks copied to the active RAM on each VBLK rising edge.
module digdug_spatr_dma
  import digdug_spr_pkg::*;
(
  input logic               RCLK,
  input logic               RESET,
  digdug_spatr_dma_if.slave bus
);

  spr_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_vblk_d;
  logic               r_frame;
  logic [7:0]         r_cpudo;
  logic [SPAT_W-1:0]  r_copy_word;

  logic [7:0]         r_sh_b0 [NENT];
  logic [7:0]         r_sh_b1 [NENT];
  logic [7:0]         r_sh_b2 [NENT];

  logic [1:0]         w_cpu_bank;
  logic [SPAT_AW-1:0] w_cpu_ent;
  logic [SPAT_AW-1:0] w_idx_lo;
  logic               w_idx_last;
  logic               w_vblk_rise;
  logic               w_busy;
  logic               w_wr_en;
  logic [SPAT_AW-1:0] w_wr_addr;
  logic [SPAT_W-1:0]  w_wr_data;
  logic [SPAT_W-1:0]  w_spatdt;

  assign w_cpu_bank  = bus.CPUAD[SPAT_AW+1:SPAT_AW];
  assign w_cpu_ent   = bus.CPUAD[SPAT_AW-1:0];
  assign w_idx_lo    = r_idx[SPAT_AW-1:0];
  assign w_idx_last  = (r_idx == IDX_W'(NENT - 1));
  assign w_vblk_rise = bus.VBLK & ~r_vblk_d;

  always_ff @(posedge RCLK) begin
    if (RESET) begin
      r_state <= StClear;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StClear: if (w_idx_last) w_state_nxt = StIdle;
      StIdle:  if (w_vblk_rise) w_state_nxt = StCopy;
      StCopy:  if (w_idx_last) w_state_nxt = StLast;
      StLast:  w_state_nxt = StIdle;
      default: w_state_nxt = StClear;
    endcase
  end

  // Copy writes trail the shadow read by one cycle, hence idx-1 as the active address.
  always_comb begin
    w_busy    = 1'b1;
    w_wr_en   = 1'b0;
    w_wr_addr = SPAT_AW'(r_idx - IDX_W'(1));
    w_wr_data = r_copy_word;
    unique case (r_state)
      StClear: begin
        w_wr_en   = ~RESET;
        w_wr_addr = w_idx_lo;
        w_wr_data = CLRWORD;
      end
      StIdle:  w_busy  = 1'b0;
      StCopy:  w_wr_en = ~RESET & (r_idx != '0);
      StLast:  w_wr_en = ~RESET;
      default: w_busy  = 1'b1;
    endcase
  end

  always_ff @(posedge RCLK) begin
    if (RESET) begin
      r_idx    <= '0;
      r_vblk_d <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_vblk_d <= bus.VBLK;
      if (r_state == StLast) begin
        r_frame <= ~r_frame;
      end
      if ((r_state == StClear) || (r_state == StCopy)) begin
        r_idx <= r_idx + IDX_W'(1);
      end else begin
        r_idx <= '0;
      end
    end
  end

  // Shadow is read-first and never reset; the CPU is never stalled by the copy engine.
  always_ff @(posedge RCLK) begin
    if (bus.CPUWR) begin
      case (w_cpu_bank)
        BANK_LO:  r_sh_b0[w_cpu_ent] <= bus.CPUDI;
        BANK_MID: r_sh_b1[w_cpu_ent] <= bus.CPUDI;
        BANK_HI:  r_sh_b2[w_cpu_ent] <= bus.CPUDI;
        default:  ;
      endcase
    end
    r_copy_word <= {r_sh_b2[w_idx_lo], r_sh_b1[w_idx_lo], r_sh_b0[w_idx_lo]};
  end

  always_ff @(posedge RCLK) begin
    if (RESET) begin
      r_cpudo <= '0;
    end else begin
      case (w_cpu_bank)
        BANK_LO:  r_cpudo <= r_sh_b0[w_cpu_ent];
        BANK_MID: r_cpudo <= r_sh_b1[w_cpu_ent];
        BANK_HI:  r_cpudo <= r_sh_b2[w_cpu_ent];
        default:  r_cpudo <= 8'hFF;
      endcase
    end
  end

  digdug_spatr_ram u_active (
    .i_clk   (RCLK),
    .i_rst   (RESET),
    .i_we    (w_wr_en),
    .i_waddr (w_wr_addr),
    .i_wdata (w_wr_data),
    .i_raddr (bus.SPATAD),
    .o_rdata (w_spatdt)
  );

  assign bus.CPUDO  = r_cpudo;
  assign bus.SPATDT = w_spatdt;
  assign bus.BUSY   = w_busy;
  assign bus.FRAME  = r_frame;

endmodule

// File: tb/tb_digdug_spatr_dma.sv
// Bench for digdug_spatr_dma: directed tables and sequences plus random traffic against a model.
module tb_digdug_spatr_dma;

  localparam int N = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;

  digdug_spatr_dma_if bus ();

  digdug_spatr_dma dut (
    .RCLK  (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  // Reference model: a pass started at edge P samples entry i at edge P+1+i (before that
  // edge's CPU write) and the entry becomes visible to the renderer at edge P+2+i.
  logic [7:0]  m_sh   [4][N];
  logic [23:0] m_act  [N];
  logic [23:0] m_pend [N];
  int          m_edge    = 0;
  int          m_idle_at = 0;
  int          m_pass    = -1;
  logic        m_prev_vblk = 1'b0;
  logic        m_frame     = 1'b0;
  logic        m_valid     = 1'b0;
  logic        m_spat_chk  = 1'b0;
  logic [7:0]  m_cpudo     = '0;
  logic [23:0] m_spat      = '0;

  always @(posedge clk) begin : model
    logic [1:0] b;
    logic [6:0] e;
    logic [6:0] a;
    int off;
    m_edge++;
    m_valid = 1'b1;
    b = bus.CPUAD[8:7];
    e = bus.CPUAD[6:0];
    a = bus.SPATAD;
    if (rst) begin
      m_cpudo     = 8'h00;
      m_spat      = 24'h0;
      m_spat_chk  = 1'b1;
      m_frame     = 1'b0;
      m_pass      = -1;
      m_prev_vblk = 1'b0;
      m_idle_at   = m_edge + N;
      for (int i = 0; i < N; i++) m_act[i] = 24'h020000;
    end else begin
      m_cpudo = (b == 2'd3) ? 8'hFF : m_sh[b][e];
      if (m_pass >= 0) begin
        off = m_edge - m_pass - 1;
        if (off >= 0 && off < N) m_pend[off] = {m_sh[2][off], m_sh[1][off], m_sh[0][off]};
        if (m_edge == m_pass + N + 1) begin
          for (int i = 0; i < N; i++) m_act[i] = m_pend[i];
          m_frame = !m_frame;
          m_pass  = -1;
        end
      end else if ((m_edge - 1 >= m_idle_at) && bus.VBLK && !m_prev_vblk) begin
        m_pass    = m_edge;
        m_idle_at = m_edge + N + 1;
      end
      m_prev_vblk = bus.VBLK;
      if (m_pass >= 0 && m_edge >= m_pass + 2 + int'(a)) m_spat = m_pend[a];
      else m_spat = m_act[a];
      m_spat_chk = !(m_pass < 0 && m_edge < m_idle_at);
    end
    if (bus.CPUWR && b != 2'd3) m_sh[b][e] = bus.CPUDI;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", {31'b0, bus.BUSY}, {31'b0, (m_edge < m_idle_at)});
      check("frame", {31'b0, bus.FRAME}, {31'b0, m_frame});
      check("cpudo", {24'b0, bus.CPUDO}, {24'b0, m_cpudo});
      if (m_spat_chk) check("spatdt", {8'b0, bus.SPATDT}, {8'b0, m_spat});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [8:0] addr, input logic [7:0] d);
    bus.CPUAD = addr;
    bus.CPUDI = d;
    bus.CPUWR = 1'b1;
    tick();
    bus.CPUWR = 1'b0;
  endtask

  task automatic read_spat(input logic [6:0] a, input string name, input logic [23:0] exp_v);
    bus.SPATAD = a;
    tick();
    check(name, {8'b0, bus.SPATDT}, {8'b0, exp_v});
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (bus.BUSY === 1'b1 && cnt < 400) begin
      cnt++;
      tick();
    end
    if (cnt >= 400) check("wait_idle_timeout", {31'b0, bus.BUSY}, 32'd0);
  endtask

  task automatic do_pass(input string tag);
    int   cnt   = 0;
    logic f0;
    logic early = 1'b0;
    bus.VBLK = 1'b0;
    tick();
    f0 = bus.FRAME;
    bus.VBLK = 1'b1;
    tick();
    while (bus.BUSY === 1'b1 && cnt < 400) begin
      cnt++;
      if (bus.FRAME !== f0) early = 1'b1;
      tick();
    end
    bus.VBLK = 1'b0;
    check({tag, "_busy_width"}, cnt, 32'd129);
    check({tag, "_frame_toggle"}, {31'b0, bus.FRAME}, {31'b0, !f0});
    check({tag, "_frame_not_early"}, {31'b0, early}, 32'd0);
  endtask

  typedef struct {
    logic [6:0]  ent;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [23:0] exp_word;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int cnt;
    int toggles;
    logic fprev;

    tbl[0] = '{ent: 7'd5,   b0: 8'h12, b1: 8'h34, b2: 8'h56, exp_word: 24'h563412};
    tbl[1] = '{ent: 7'd9,   b0: 8'hCC, b1: 8'hBB, b2: 8'hAA, exp_word: 24'hAABBCC};
    tbl[2] = '{ent: 7'd0,   b0: 8'h00, b1: 8'h00, b2: 8'h00, exp_word: 24'h000000};
    tbl[3] = '{ent: 7'd127, b0: 8'hFF, b1: 8'hEE, b2: 8'hDD, exp_word: 24'hDDEEFF};
    tbl[4] = '{ent: 7'd64,  b0: 8'h01, b1: 8'h02, b2: 8'h03, exp_word: 24'h030201};

    bus.VBLK   = 1'b0;
    bus.CPUWR  = 1'b0;
    bus.CPUAD  = '0;
    bus.CPUDI  = '0;
    bus.SPATAD = '0;
    rst        = 1'b1;
    repeat (3) tick();

    // Fill the whole shadow under reset so every byte is known to the model.
    for (int bk = 0; bk < 3; bk++)
      for (int en = 0; en < N; en++) cpu_wr({bk[1:0], en[6:0]}, 8'($urandom));
    check("reset_cpudo", {24'b0, bus.CPUDO}, 32'd0);
    check("reset_spatdt", {8'b0, bus.SPATDT}, 32'd0);

    // Reset clear: BUSY width and every entry disabled.
    rst = 1'b0;
    cnt = 0;
    while (bus.BUSY === 1'b1 && cnt < 400) begin
      cnt++;
      tick();
    end
    check("clear_busy_len", cnt, 32'd128);
    check("clear_frame", {31'b0, bus.FRAME}, 32'd0);
    for (int i = 0; i < N; i++) read_spat(i[6:0], "clear_word", 24'h020000);

    // Table-driven basic copy.
    foreach (tbl[i]) begin
      cpu_wr({2'd0, tbl[i].ent}, tbl[i].b0);
      cpu_wr({2'd1, tbl[i].ent}, tbl[i].b1);
      cpu_wr({2'd2, tbl[i].ent}, tbl[i].b2);
    end
    do_pass("basic");
    check("basic_frame_one", {31'b0, bus.FRAME}, 32'd1);
    foreach (tbl[i]) read_spat(tbl[i].ent, "basic_entry", tbl[i].exp_word);

    // Frame isolation: shadow update is invisible until the next pass.
    cpu_wr({2'd0, 7'd9}, 8'h33);
    cpu_wr({2'd1, 7'd9}, 8'h22);
    cpu_wr({2'd2, 7'd9}, 8'h11);
    for (int k = 0; k < 4; k++) read_spat(7'd9, "isolate_old", 24'hAABBCC);
    do_pass("isolate");
    read_spat(7'd9, "isolate_new", 24'h112233);

    // Collision: write entry 40 on the exact edge it is read; entry 100 ahead of its read.
    cpu_wr({2'd0, 7'd40}, 8'h5A);
    cpu_wr({2'd0, 7'd100}, 8'h11);
    bus.VBLK = 1'b0;
    tick();
    bus.VBLK = 1'b1;
    repeat (41) tick();
    bus.CPUAD = {2'd0, 7'd40};
    bus.CPUDI = 8'hA5;
    bus.CPUWR = 1'b1;
    tick();
    bus.CPUAD = {2'd0, 7'd100};
    bus.CPUDI = 8'h22;
    tick();
    bus.CPUWR = 1'b0;
    wait_idle();
    bus.VBLK = 1'b0;
    bus.SPATAD = 7'd40;
    tick();
    check("collide_old_byte", {24'b0, bus.SPATDT[7:0]}, 32'h5A);
    bus.SPATAD = 7'd100;
    tick();
    check("ahead_new_byte", {24'b0, bus.SPATDT[7:0]}, 32'h22);
    do_pass("collide_next");
    bus.SPATAD = 7'd40;
    tick();
    check("collide_next_byte", {24'b0, bus.SPATDT[7:0]}, 32'hA5);

    // Retrigger: extra VBLK edges inside a pass are dropped.
    bus.VBLK = 1'b0;
    tick();
    fprev   = bus.FRAME;
    toggles = 0;
    cnt     = 0;
    bus.VBLK = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k == 10) bus.VBLK = 1'b0;
      if (k == 20) bus.VBLK = 1'b1;
      if (k == 30) bus.VBLK = 1'b0;
      if (bus.BUSY === 1'b1) cnt++;
      if (bus.FRAME !== fprev) toggles++;
      fprev = bus.FRAME;
    end
    check("retrig_busy_width", cnt, 32'd129);
    check("retrig_toggles", toggles, 32'd1);

    // Bank 3 is unmapped.
    cpu_wr(9'h180, 8'h77);
    bus.CPUAD = 9'h180;
    tick();
    check("bank3_read", {24'b0, bus.CPUDO}, 32'hFF);
    bus.CPUAD = 9'h000;
    tick();
    check("bank3_no_alias", {24'b0, bus.CPUDO}, {24'b0, m_sh[0][0]});

    // Random traffic; the negedge checker compares every cycle against the model.
    for (int k = 0; k < 3000; k++) begin
      bus.CPUWR  = 1'($urandom_range(0, 1));
      bus.CPUAD  = 9'($urandom);
      bus.CPUDI  = 8'($urandom);
      bus.SPATAD = 7'($urandom);
      if ($urandom_range(0, 59) == 0) bus.VBLK = ~bus.VBLK;
      tick();
    end
    bus.CPUWR = 1'b0;
    bus.VBLK  = 1'b0;
    tick();
    wait_idle();

    // Reset in the middle of a copy pass.
    bus.VBLK = 1'b1;
    repeat (60) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (bus.BUSY === 1'b1 && cnt < 400) begin
      cnt++;
      tick();
    end
    check("midreset_busy_len", cnt, 32'd128);
    check("midreset_frame", {31'b0, bus.FRAME}, 32'd0);
    bus.VBLK = 1'b0;
    for (int i = 0; i < N; i++) read_spat(i[6:0], "midreset_word", 24'h020000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
